seg_scan_mux: RTL and testbench
===============================

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_DIGITS, 4: digit count; legal range 2..8.
- SEG_W, 7: segments per digit.
- REFRESH_DIV, 100000: clk cycles per scan slot; minimum 2.
- BLINK_TICKS, 256: scan slots per blink half-period; minimum 1.
- BLANK_CYCLES, 16: gap length; used only under REQ-022; minimum 1.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock; all state on rising edge.
- rst, in, 1: asynchronous, active-high reset.
- en, in, 1: display enable.
- seg_in, in, NUM_DIGITS*SEG_W: active-low cathode patterns; digit i in bits [i*SEG_W +: SEG_W]; digit 0 is leftmost.
- blink_mask, in, NUM_DIGITS: bit i=1 makes digit i blink.
- cathode, out, SEG_W: active-low segments, registered.
- anode, out, NUM_DIGITS: active-low digit selects, registered.
- scan_idx, out, clog2(NUM_DIGITS): digit currently driven, registered.

Function
REQ-003 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0.
REQ-004 A tick SHALL be asserted in the cycle the prescaler equals REFRESH_DIV-1.
REQ-005 On each tick, scan_idx SHALL advance by 1, wrapping from NUM_DIGITS-1 to 0; non-power-of-2 NUM_DIGITS SHALL never reach unused codes.
REQ-006 Digit i SHALL be selected by driving anode[NUM_DIGITS-1-i] low with all other anode bits high; at most one anode bit is low in any cycle.
REQ-007 Every cycle, cathode SHALL register the seg_in slice of the digit selected in that same cycle, so seg_in changes appear one cycle later, without waiting for a tick.
REQ-008 The blink counter SHALL count ticks 0..BLINK_TICKS-1; on its wrap, blink_phase SHALL toggle.
REQ-009 A digit with blink_mask[i]=1 and blink_phase=0 SHALL drive cathode all-ones while its anode stays active.
REQ-010 When en=0, anode and cathode SHALL be all-ones from the next cycle. Prescaler, scan_idx and blink state SHALL keep running.
REQ-011 When en returns to 1, display SHALL resume at the current scan_idx with no restart.
REQ-012 If a tick and a blink wrap occur in the same cycle, the advanced digit SHALL use the new blink_phase.
REQ-013 blink_mask SHALL be sampled every cycle, with the same timing as seg_in.

Reset
REQ-014 While rst=1, these values SHALL hold:
- prescaler=0, scan_idx=0, blink counter=0, blink_phase=0.
- anode all-ones, cathode all-ones.
- gap state machine in SHOW.
REQ-015 Reset assertion SHALL take effect asynchronously, including mid-slot and mid-gap.
REQ-016 After rst deassertion, the first tick SHALL occur REFRESH_DIV cycles later; digit 0 SHALL be displayed from the first enabled cycle.

Configuration
REQ-020 Macro SEG_SCAN_BLANK_GAP_EN SHALL control the anti-ghost gap.
REQ-021 Without the macro, scan_idx SHALL advance directly on tick per REQ-005, with no gap and no state machine.
REQ-022 With the macro, a two-state FSM (SHOW, GAP) SHALL be compiled in:
- SHOW to GAP on tick; anode SHALL be all-ones for BLANK_CYCLES cycles.
- GAP to SHOW after BLANK_CYCLES cycles; scan_idx SHALL advance on that exit edge.
- Prescaler SHALL hold at 0 during GAP.
- cathode SHALL be all-ones during GAP.
- en=0 during GAP SHALL NOT shorten the gap.

Verification
REQ-030 Bench parameters SHALL be NUM_DIGITS=4, REFRESH_DIV=4, BLINK_TICKS=2.
REQ-031 Reset scenario: assert rst mid-slot -> anode=4'b1111 and cathode=7'h7F immediately; scan_idx=0 after release.
REQ-032 Scan scenario: seg_in={7'h40,7'h79,7'h24,7'h30}, blink_mask=0 -> anode sequence 0111, 1011, 1101, 1110 every 4 cycles, then wrap; cathode matches the slice of the selected digit.
REQ-033 Blink scenario: blink_mask=4'b0001 -> digit 0 shows 7'h7F during slots with blink_phase=0 and its pattern otherwise; blink_phase toggles every 2 ticks.
REQ-034 Enable scenario: drop en for 6 cycles -> outputs all-ones one cycle later; scan_idx on re-enable equals its value from the free-running count.
REQ-035 Gap scenario: with SEG_SCAN_BLANK_GAP_EN and BLANK_CYCLES=3 -> after each 4-cycle slot, anode=1111 for exactly 3 cycles, then the next digit.
REQ-036 Non-power-of-2 scenario: NUM_DIGITS=3 -> scan_idx cycles 0,1,2,0 and never reaches 3.

Source files
------------

// File: rtl/seg_scan_mux.sv
`timescale 1ns/1ps
// seg_scan_mux: time-multiplexed driver for an active-low multi-digit segment display.
// Latency: en/seg_in/blink_mask reach anode/cathode one clk later; digit advances every REFRESH_DIV clks.
// No backpressure. Define SEG_SCAN_BLANK_GAP_EN to insert a BLANK_CYCLES anti-ghost gap between digits.
module seg_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int SEG_W        = 7,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_TICKS  = 256,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [NUM_DIGITS*SEG_W-1:0]      seg_in,
  input  logic [NUM_DIGITS-1:0]            blink_mask,
  output logic [SEG_W-1:0]                 cathode,
  output logic [NUM_DIGITS-1:0]            anode,
  output logic [$clog2(NUM_DIGITS)-1:0]    scan_idx
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_TICKS - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             phase_q, phase_d;
  logic             tick;
  logic             blank;

  logic [SEG_W-1:0]      sel_seg;
  logic                  sel_blink;
  logic [NUM_DIGITS-1:0] dec_anode;
  logic [SEG_W-1:0]      cathode_d;
  logic [NUM_DIGITS-1:0] anode_d;

  // Next digit index, wrapping at the last real digit so unused codes are never reached.
  assign idx_inc = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;

`ifdef SEG_SCAN_BLANK_GAP_EN
  localparam int GAP_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(BLANK_CYCLES - 1);

  typedef enum logic {SHOW, GAP} gap_state_t;

  gap_state_t       state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  // Gap FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SHOW;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Slot timing: a tick opens the gap; the digit only advances when the gap closes.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    pre_d     = pre_q;
    idx_d     = idx_q;
    tick      = 1'b0;
    case (state_q)
      SHOW: begin
        if (pre_q == PRE_MAX) begin
          tick      = 1'b1;
          pre_d     = '0;
          state_d   = GAP;
          gap_cnt_d = '0;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      GAP: begin
        pre_d = '0;
        if (gap_cnt_q == GAP_MAX) begin
          state_d = SHOW;
          idx_d   = idx_inc;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = SHOW;
    endcase
  end

  assign blank = (state_d == GAP);
`else
  // Gap length only matters when the gap feature is compiled in.
  if (BLANK_CYCLES < 1) begin : g_blank_cycles_unused
  end

  // Slot timing: free-running prescaler, digit advances directly on tick.
  always_comb begin
    tick  = (pre_q == PRE_MAX);
    pre_d = tick ? '0 : pre_q + 1'b1;
    idx_d = tick ? idx_inc : idx_q;
  end

  assign blank = 1'b0;
`endif

  // Blink counter counts ticks; phase flips on its wrap and is visible to the digit advanced by the same tick.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    phase_d   = phase_q;
    if (tick) begin
      if (blk_cnt_q == BLK_MAX) begin
        blk_cnt_d = '0;
        phase_d   = ~phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + 1'b1;
      end
    end
  end

  // Output mux: pick the slice for the digit that will be selected next cycle, then apply enable/gap/blink blanking.
  always_comb begin
    sel_seg   = '1;
    sel_blink = 1'b0;
    dec_anode = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        sel_seg                    = seg_in[i*SEG_W +: SEG_W];
        sel_blink                  = blink_mask[i];
        dec_anode[NUM_DIGITS-1-i]  = 1'b0;
      end
    end
    if (!en || blank) begin
      anode_d   = '1;
      cathode_d = '1;
    end else begin
      anode_d   = dec_anode;
      cathode_d = (sel_blink && !phase_d) ? '1 : sel_seg;
    end
  end

  // Scan state and registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q     <= '0;
      idx_q     <= '0;
      blk_cnt_q <= '0;
      phase_q   <= 1'b0;
      anode     <= '1;
      cathode   <= '1;
    end else begin
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
      anode     <= anode_d;
      cathode   <= cathode_d;
    end
  end

  assign scan_idx = idx_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
`timescale 1ns/1ps
// tb_seg_scan_mux: table-driven and scoreboard checks of seg_scan_mux.
// Main instance: 4 digits; second instance: 3 digits for index wrap.
// Clock runs freely; every check samples 1ns after the rising edge.
module tb_seg_scan_mux;
  localparam int N  = 4;
  localparam int W  = 7;
  localparam int RD = 4;
  localparam int BT = 2;
  localparam int BC = 3;
  localparam int N3 = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [N*W-1:0]   seg_in;
  logic [N-1:0]     blink_mask;
  logic [W-1:0]     cathode;
  logic [N-1:0]     anode;
  logic [1:0]       scan_idx;

  logic [N3*W-1:0]  seg3 = '0;
  logic [N3-1:0]    mask3 = '0;
  logic [W-1:0]     cath3;
  logic [N3-1:0]    an3;
  logic [1:0]       idx3;

  seg_scan_mux #(.NUM_DIGITS(N), .SEG_W(W), .REFRESH_DIV(RD), .BLINK_TICKS(BT), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .en(en), .seg_in(seg_in), .blink_mask(blink_mask),
    .cathode(cathode), .anode(anode), .scan_idx(scan_idx));

  seg_scan_mux #(.NUM_DIGITS(N3), .SEG_W(W), .REFRESH_DIV(RD), .BLINK_TICKS(BT), .BLANK_CYCLES(BC)) dut3 (
    .clk(clk), .rst(rst), .en(en), .seg_in(seg3), .blink_mask(mask3),
    .cathode(cath3), .anode(an3), .scan_idx(idx3));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {int pre; int idx; int bcnt; int phase; int gap; int gcnt;} mst_t;
  typedef struct {logic [3:0] anode; logic [6:0] cath; int idx; int idx3;} exp_t;
  typedef struct {logic en; logic [3:0] mask; logic [3:0] anode; logic [6:0] cath; int idx;} vec_t;
  typedef struct {logic en; logic [3:0] mask; int cycles; bit rnd;} phase_t;

  mst_t m, m3;
  exp_t q[$];

  localparam logic [N*W-1:0] PATTERN = {7'h40, 7'h79, 7'h24, 7'h30};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mst_t st_reset();
    mst_t r;
    r = '{0, 0, 0, 0, 0, 0};
    return r;
  endfunction

  // Reference behaviour for one clock edge.
  function automatic mst_t mstep(mst_t s, int n);
    mst_t r;
    bit   tk;
    r  = s;
    tk = 1'b0;
    if (s.gap != 0) begin
      r.pre = 0;
      if (s.gcnt == BC - 1) begin
        r.gap  = 0;
        r.gcnt = 0;
        r.idx  = (s.idx + 1) % n;
      end else begin
        r.gcnt = s.gcnt + 1;
      end
    end else begin
      tk    = (s.pre == RD - 1);
      r.pre = (s.pre + 1) % RD;
      if (tk) begin
`ifdef SEG_SCAN_BLANK_GAP_EN
        r.gap  = 1;
        r.gcnt = 0;
`else
        r.idx = (s.idx + 1) % n;
`endif
      end
    end
    if (tk) begin
      r.bcnt = (s.bcnt + 1) % BT;
      if (s.bcnt == BT - 1) r.phase = 1 - s.phase;
    end
    return r;
  endfunction

  function automatic exp_t mout(mst_t s, logic e, logic [N*W-1:0] seg, logic [N-1:0] mask);
    exp_t x;
    x.idx  = s.idx;
    x.idx3 = 0;
    if (!e || s.gap != 0) begin
      x.anode = 4'hF;
      x.cath  = 7'h7F;
    end else begin
      x.anode = 4'hF & ~(4'b1000 >> s.idx);
      x.cath  = (mask[s.idx] && s.phase == 0) ? 7'h7F : seg[s.idx*W +: W];
    end
    return x;
  endfunction

  // Push the expected result for the coming edge, run the edge, then pop and compare.
  task automatic run_cycle(input bit use_tab, input vec_t tv);
    exp_t e, got;
    if (rst) begin
      m  = st_reset();
      m3 = st_reset();
      e  = '{4'hF, 7'h7F, 0, 0};
    end else begin
      m  = mstep(m, N);
      m3 = mstep(m3, N3);
      e  = mout(m, en, seg_in, blink_mask);
      e.idx3 = m3.idx;
      if (use_tab) begin
        e.anode = tv.anode;
        e.cath  = tv.cath;
        e.idx   = tv.idx;
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    got = q.pop_front();
    check("anode",     {28'b0, anode},    {28'b0, got.anode});
    check("cathode",   {25'b0, cathode},  {25'b0, got.cath});
    check("scan_idx",  {30'b0, scan_idx}, got.idx);
    check("idx3",      {30'b0, idx3},     got.idx3);
    check("idx3_range", {31'b0, (idx3 < 2'd3)}, 32'd1);
  endtask

  vec_t   tab[17];
  phase_t ph[6];
  vec_t   nov;

  initial begin
    // Scan after reset release, pattern digits 0..3 = 30,24,79,40 (first slot is one cycle short).
    tab[0]  = '{1'b1, 4'h0, 4'b0111, 7'h30, 0};
    tab[1]  = '{1'b1, 4'h0, 4'b0111, 7'h30, 0};
    tab[2]  = '{1'b1, 4'h0, 4'b0111, 7'h30, 0};
    tab[3]  = '{1'b1, 4'h0, 4'b1011, 7'h24, 1};
    tab[4]  = '{1'b1, 4'h0, 4'b1011, 7'h24, 1};
    tab[5]  = '{1'b1, 4'h0, 4'b1011, 7'h24, 1};
    tab[6]  = '{1'b1, 4'h0, 4'b1011, 7'h24, 1};
    tab[7]  = '{1'b1, 4'h0, 4'b1101, 7'h79, 2};
    tab[8]  = '{1'b1, 4'h0, 4'b1101, 7'h79, 2};
    tab[9]  = '{1'b1, 4'h0, 4'b1101, 7'h79, 2};
    tab[10] = '{1'b1, 4'h0, 4'b1101, 7'h79, 2};
    tab[11] = '{1'b1, 4'h0, 4'b1110, 7'h40, 3};
    tab[12] = '{1'b1, 4'h0, 4'b1110, 7'h40, 3};
    tab[13] = '{1'b1, 4'h0, 4'b1110, 7'h40, 3};
    tab[14] = '{1'b1, 4'h0, 4'b1110, 7'h40, 3};
    tab[15] = '{1'b1, 4'h0, 4'b0111, 7'h30, 0};
    tab[16] = '{1'b1, 4'h0, 4'b0111, 7'h30, 0};

    ph[0] = '{1'b1, 4'b0001, 32, 1'b0};
    ph[1] = '{1'b1, 4'b0100, 32, 1'b0};
    ph[2] = '{1'b0, 4'b0000, 6,  1'b0};
    ph[3] = '{1'b1, 4'b0000, 12, 1'b0};
    ph[4] = '{1'b1, 4'b0000, 24, 1'b1};
    ph[5] = '{1'b1, 4'b1010, 20, 1'b1};
    nov   = '{1'b0, 4'h0, 4'h0, 7'h0, 0};

    rst        = 1'b1;
    en         = 1'b1;
    seg_in     = PATTERN;
    blink_mask = '0;
    m          = st_reset();
    m3         = st_reset();
    #1;
    check("rst_anode",   {28'b0, anode},    32'hF);
    check("rst_cathode", {25'b0, cathode},  32'h7F);
    check("rst_idx",     {30'b0, scan_idx}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rel_idx",   {30'b0, scan_idx}, 32'd0);
    check("rel_anode", {28'b0, anode},    32'hF);

    for (int k = 0; k < 17; k++) begin
      en         = tab[k].en;
      blink_mask = tab[k].mask;
`ifdef SEG_SCAN_BLANK_GAP_EN
      run_cycle(1'b0, tab[k]);
`else
      run_cycle(1'b1, tab[k]);
`endif
    end

    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < ph[p].cycles; c++) begin
        en         = ph[p].en;
        blink_mask = ph[p].rnd ? 4'($urandom_range(0, 15)) : ph[p].mask;
        if (ph[p].rnd) seg_in = {4{7'($urandom_range(0, 127))}} ^ PATTERN ^ 28'($urandom);
        run_cycle(1'b0, nov);
      end
    end

    // Asynchronous reset in the middle of a slot.
    seg_in     = PATTERN;
    blink_mask = '0;
    en         = 1'b1;
    for (int c = 0; c < 8 && m.pre != 2; c++) run_cycle(1'b0, nov);
    check("midslot_pre", m.pre, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("async_anode",   {28'b0, anode},    32'hF);
    check("async_cathode", {25'b0, cathode},  32'h7F);
    check("async_idx",     {30'b0, scan_idx}, 32'd0);
    m  = st_reset();
    m3 = st_reset();
    run_cycle(1'b0, nov);
    run_cycle(1'b0, nov);
    rst = 1'b0;
    #1;
    check("rerel_idx", {30'b0, scan_idx}, 32'd0);
    for (int c = 0; c < 20; c++) run_cycle(1'b0, nov);

`ifdef SEG_SCAN_BLANK_GAP_EN
    // Each blank run between shown digits lasts exactly BC cycles.
    begin
      int run_len;
      int gaps;
      bit shown;
      run_len = 0;
      gaps    = 0;
      shown   = 1'b0;
      for (int c = 0; c < 60 && gaps < 3; c++) begin
        run_cycle(1'b0, nov);
        if (anode == 4'hF) begin
          run_len++;
        end else begin
          if (shown && run_len != 0) begin
            check("gap_len", run_len, BC);
            gaps++;
          end
          shown   = 1'b1;
          run_len = 0;
        end
      end
      check("gap_seen", gaps, 32'd3);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
